// File: rtl/uart_tx.sv
// UART transmit serializer: one-entry holding buffer feeding an LSB-first shifter
// that emits start, data, optional parity and stop bits on each baud_tick.
module uart_tx #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  state_e                 state_q, state_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   buf_q, buf_d;
  logic                   full_q, full_d;
  logic                   par_q, par_d;
  logic [3:0]             bcnt_q, bcnt_d;
  logic                   scnt_q, scnt_d;
  logic                   tx_q, tx_d;
  logic                   ready_q, busy_q;
  logic                   load;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    buf_d   = buf_q;
    full_d  = full_q;
    par_d   = par_q;
    bcnt_d  = bcnt_q;
    scnt_d  = scnt_q;
    tx_d    = tx_q;
    load    = 1'b0;

    // Accept and load never coincide: accept needs an empty buffer, load a full one.
    if (tx_valid && ready_q) begin
      buf_d  = tx_data;
      full_d = 1'b1;
    end

    if (baud_tick) begin
      case (state_q)
        S_IDLE: begin
          if (full_q) load = 1'b1;
          else        tx_d = 1'b1;
        end
        S_START: begin
          tx_d    = shift_q[0];
          bcnt_d  = '0;
          state_d = S_DATA;
        end
        S_DATA: begin
          if (bcnt_q < 4'(DATA_BITS - 1)) begin
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
            bcnt_d  = bcnt_q + 4'd1;
          end else if (PARITY != 0) begin
            tx_d    = par_q;
            state_d = S_PARITY;
          end else begin
            tx_d    = 1'b1;
            scnt_d  = 1'b0;
            state_d = S_STOP;
          end
        end
        S_PARITY: begin
          tx_d    = 1'b1;
          scnt_d  = 1'b0;
          state_d = S_STOP;
        end
        S_STOP: begin
          if (STOP_BITS == 2 && !scnt_q) begin
            scnt_d = 1'b1;
            tx_d   = 1'b1;
          end else if (full_q) begin
            load = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Shared by IDLE start and zero-gap restart from the final stop tick.
    if (load) begin
      shift_d = buf_q;
      par_d   = (PARITY == 1) ? ~^buf_q : ^buf_q;
      tx_d    = 1'b0;
      full_d  = 1'b0;
      state_d = S_START;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      buf_q   <= '0;
      full_q  <= 1'b0;
      par_q   <= 1'b0;
      bcnt_q  <= '0;
      scnt_q  <= 1'b0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      buf_q   <= buf_d;
      full_q  <= full_d;
      par_q   <= par_d;
      bcnt_q  <= bcnt_d;
      scnt_q  <= scnt_d;
      tx_q    <= tx_d;
      ready_q <= !full_d;
      busy_q  <= (state_d != S_IDLE) | full_d;
    end
  end

  assign tx       = tx_q;
  assign tx_ready = ready_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: several parameter sets driven in parallel, each checked every
// cycle against a bit-queue model of the serial line plus a few literal frames.
module tb_uart_tx;
  localparam int NI = 6;

  function automatic int cfg_db(input int i);
    case (i) 4: return 9; 5: return 5; default: return 8; endcase
  endfunction
  function automatic int cfg_par(input int i);
    case (i) 1: return 2; 2: return 1; 4: return 1; 5: return 2; default: return 0; endcase
  endfunction
  function automatic int cfg_stop(input int i);
    case (i) 3: return 2; 4: return 2; default: return 1; endcase
  endfunction

  logic          clk, rst_n, baud_tick, tx_valid;
  logic [8:0]    tx_data;
  logic [NI-1:0] rdy_w, tx_w, busy_w;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int DB = cfg_db(g);
    uart_tx #(.DATA_BITS(DB), .PARITY(cfg_par(g)), .STOP_BITS(cfg_stop(g))) u_dut (
      .clk(clk), .reset(rst_n), .baud_tick(baud_tick), .tx_data(tx_data[DB-1:0]),
      .tx_valid(tx_valid), .tx_ready(rdy_w[g]), .tx(tx_w[g]), .busy(busy_w[g]));
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string nm, input int idx, input int act, input int exp_v);
    n_chk++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s[%0d] @%0t: got %0d, want %0d", nm, idx, $time, act, exp_v);
  endtask

  // Model: the line is a queue of bits still to be sent; each tick puts the next
  // one on tx, pulling a whole frame from the one-slot buffer when the queue runs dry.
  bit         lq[NI][$];
  bit         mfull[NI], mact[NI], mtx[NI];
  logic [8:0] mbuf[NI];

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      lq[i].delete(); mfull[i] = 0; mact[i] = 0; mtx[i] = 1; mbuf[i] = '0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < NI; i++) begin
      bit acc;
      int ones;
      acc = tx_valid && !mfull[i];
      if (baud_tick) begin
        if (lq[i].size() > 0) mtx[i] = lq[i].pop_front();
        else if (mfull[i]) begin
          ones = 0;
          lq[i].push_back(1'b0);
          for (int k = 0; k < cfg_db(i); k++) begin
            lq[i].push_back(mbuf[i][k]);
            ones += int'(mbuf[i][k]);
          end
          if (cfg_par(i) == 2) lq[i].push_back(bit'(ones % 2));
          if (cfg_par(i) == 1) lq[i].push_back(bit'((ones + 1) % 2));
          for (int k = 0; k < cfg_stop(i); k++) lq[i].push_back(1'b1);
          mtx[i] = lq[i].pop_front();
          mfull[i] = 0;
          mact[i] = 1;
        end else begin
          mtx[i] = 1; mact[i] = 0;
        end
      end
      if (acc) begin mbuf[i] = tx_data; mfull[i] = 1; end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  initial forever begin
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk("tx", i, int'(tx_w[i]), int'(mtx[i]));
      chk("tx_ready", i, int'(rdy_w[i]), int'(!mfull[i]));
      chk("busy", i, int'(busy_w[i]), int'(mact[i] | mfull[i]));
    end
  end

  // Stimulus
  int   tmode = 0, tcnt = 0, ncap = 0;
  bit   prev_tick = 0, prev_arm = 0, cap_on = 0;
  bit   cap[NI][12];

  task automatic clk_step(input logic v, input logic [8:0] d, output logic a0);
    @(negedge clk);
    if (prev_arm && prev_tick && ncap < 12) begin
      for (int i = 0; i < NI; i++) cap[i][ncap] = tx_w[i];
      ncap++;
    end
    a0 = v & rdy_w[0];
    case (tmode)
      0: begin baud_tick = (tcnt == 9); tcnt = (tcnt == 9) ? 0 : tcnt + 1; end
      1: baud_tick = ($urandom_range(0, 3) == 0);
      default: baud_tick = 1'b1;
    endcase
    tx_valid  = v;
    tx_data   = d;
    prev_tick = baud_tick;
    prev_arm  = cap_on;
  endtask

  task automatic idle(input int n);
    logic a;
    for (int k = 0; k < n; k++) clk_step(1'b0, 9'h0, a);
  endtask

  task automatic send(input logic [8:0] d);
    logic a;
    int   n;
    a = 0; n = 0;
    while (!a && n < 2000) begin clk_step(1'b1, d, a); n++; end
    chk("send_accepted", int'(d), int'(a), 1);
  endtask

  initial begin
    logic [9:0] f0;
    logic       a, hv;
    logic [8:0] hd;
    int         lows;
    rst_n = 1'b0; baud_tick = 1'b0; tx_valid = 1'b0; tx_data = '0;
    idle(3);
    for (int i = 0; i < NI; i++) begin
      chk("rst_tx", i, int'(tx_w[i]), 1);
      chk("rst_ready", i, int'(rdy_w[i]), 1);
      chk("rst_busy", i, int'(busy_w[i]), 0);
    end
    rst_n = 1'b1;
    idle(300);

    // One 0xA5 frame into every instance, ticks captured after the accept edge.
    clk_step(1'b1, 9'h0A5, a);
    chk("a5_accept", 0, int'(a), 1);
    cap_on = 1;
    idle(125);
    cap_on = 0;
    chk("a5_ncap", 0, ncap, 12);
    f0 = 10'b1101001010;
    for (int k = 0; k < 10; k++) chk("a5_frame_p0", k, int'(cap[0][k]), int'(f0[k]));
    chk("a5_idle_p0", 0, int'(cap[0][10]), 1);
    chk("a5_even_par", 1, int'(cap[1][9]), 0);
    chk("a5_even_stop", 1, int'(cap[1][10]), 1);
    chk("a5_odd_par", 2, int'(cap[2][9]), 1);
    chk("a5_stop2", 3, int'(cap[3][10]), 1);
    chk("a5_db9_bit8", 4, int'(cap[4][9]), 0);
    chk("a5_db9_odd", 4, int'(cap[4][10]), 1);
    chk("a5_db5_even", 5, int'(cap[5][6]), 0);
    chk("a5_db5_stop", 5, int'(cap[5][7]), 1);

    // Back-to-back, then two-stop-bit streaming.
    send(9'h055); send(9'h00F); idle(300);
    send(9'h0FF); send(9'h000); idle(300);

    // Reset mid-frame with a byte buffered.
    send(9'h03C); send(9'h0C3); idle(45);
    @(posedge clk); #2 rst_n = 1'b0; #1;
    for (int i = 0; i < NI; i++) begin
      chk("midrst_tx", i, int'(tx_w[i]), 1);
      chk("midrst_ready", i, int'(rdy_w[i]), 1);
      chk("midrst_busy", i, int'(busy_w[i]), 0);
    end
    idle(3);
    rst_n = 1'b1;
    lows = 0;
    for (int k = 0; k < 100; k++) begin
      clk_step(1'b0, 9'h0, a);
      if (!tx_w[0]) lows++;
    end
    chk("postrst_idle_lows", 0, lows, 0);

    // Random traffic: sparse random ticks, then a tick every clock.
    hv = 0; hd = '0;
    for (int ph = 1; ph <= 2; ph++) begin
      tmode = ph;
      for (int k = 0; k < (ph == 1 ? 3000 : 600); k++) begin
        if (!hv && $urandom_range(0, 5) == 0) begin hv = 1; hd = 9'($urandom); end
        clk_step(hv, hd, a);
        if (a) hv = 0;
      end
    end
    tmode = 0;
    idle(300);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
